// File: rtl/alu_muldiv_sequencer_if.sv
// Bus between the execute stage and the MULTU/DIVU sequencer: request
// handshake, 64-bit result, and the shared ALU input/output bus.
interface alu_muldiv_sequencer_if;
  logic        Start;
  logic        Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;

  // Core / ALU side: issues requests and returns the ALU result.
  modport master (
    output Start, Op, OpA, OpB, ALUResult,
    input  Busy, Done, Hi, Lo, ALUControl, SrcA, SrcB
  );

  // Sequencer side.
  modport slave (
    input  Start, Op, OpA, OpB, ALUResult,
    output Busy, Done, Hi, Lo, ALUControl, SrcA, SrcB
  );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MULTU / DIVU built on the shared combinational ALU.
// MULTU: 32 shift-and-add steps. DIVU: restoring division, one SLTU compare
// and one SUB per quotient bit. Result is returned in Hi/Lo.
module alu_muldiv_sequencer #(
  parameter logic [3:0] ALU_ADD  = 4'b0010,
  parameter logic [3:0] ALU_SUB  = 4'b0110,
  parameter logic [3:0] ALU_SLTU = 4'b1001
) (
  input  logic                        clk,
  input  logic                        rst_n,
  alu_muldiv_sequencer_if.slave       bus
);

  typedef enum logic [2:0] {IDLE, MUL, DIV_CMP, DIV_SUB, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] opnd;      // multiplicand M or divisor D, depending on Op
  logic [4:0]  cnt;
  logic        ge;        // partial remainder >= divisor, from DIV_CMP
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] shifted;   // partial remainder shifted left by one bit
  logic        top;       // bit shifted out of the partial remainder
  logic        carry;     // carry out of the MUL addition
  logic        last_iter;

  assign shifted   = {hi[30:0], lo[31]};
  assign top       = hi[31];
  assign carry     = (bus.ALUResult < hi);
  assign last_iter = (cnt == 5'd31);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state logic and ALU bus drive; the bus is idle outside MUL/DIV states.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    alu_ctrl  = 4'b0000;
    src_a     = '0;
    src_b     = '0;
    unique case (state)
      IDLE: begin
        if (bus.Start) state_nxt = bus.Op ? DIV_CMP : MUL;
      end
      MUL: begin
        alu_ctrl = ALU_ADD;
        src_a    = hi;
        src_b    = lo[0] ? opnd : '0;
        if (last_iter) state_nxt = DONE;
      end
      DIV_CMP: begin
        alu_ctrl  = ALU_SLTU;
        src_a     = shifted;
        src_b     = opnd;
        state_nxt = DIV_SUB;
      end
      DIV_SUB: begin
        alu_ctrl  = ALU_SUB;
        src_a     = shifted;
        src_b     = opnd;
        state_nxt = last_iter ? DONE : DIV_CMP;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: operand load on accept, then one step per ALU op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
      cnt  <= '0;
      ge   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            hi   <= '0;
            lo   <= bus.Op ? bus.OpA : bus.OpB;
            opnd <= bus.Op ? bus.OpB : bus.OpA;
            cnt  <= '0;
          end
        end
        MUL: begin
          {hi, lo} <= {carry, bus.ALUResult, lo[31:1]};
          cnt      <= cnt + 5'd1;
        end
        DIV_CMP: begin
          // When top is set the shifted remainder exceeds 32 bits, so it is
          // necessarily >= D and the wrapped SUB result is the true remainder.
          ge <= top | ~bus.ALUResult[0];
        end
        DIV_SUB: begin
          hi  <= ge ? bus.ALUResult : shifted;
          lo  <= {lo[30:0], ge};
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy       = (state != IDLE);
  assign bus.Done       = (state == DONE);
  assign bus.Hi         = hi;
  assign bus.Lo         = lo;
  assign bus.ALUControl = alu_ctrl;
  assign bus.SrcA       = src_a;
  assign bus.SrcB       = src_b;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: a behavioural ALU, a vector
// table, random operands checked against a reference model, and hand-written
// sequences for ignored Start, back-to-back requests and mid-operation reset.
module tb_alu_muldiv_sequencer;

  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] SLTU = 4'b1001;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];
  res_t last_res;
  vec_t vecs[8];

  alu_muldiv_sequencer_if bus ();

  alu_muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU closing the loop.
  always_comb begin
    case (bus.ALUControl)
      ADD:     bus.ALUResult = bus.SrcA + bus.SrcB;
      SUB:     bus.ALUResult = bus.SrcA - bus.SrcB;
      SLTU:    bus.ALUResult = {31'b0, (bus.SrcA < bus.SrcB)};
      default: bus.ALUResult = '0;
    endcase
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [63:0] p;
    if (!op) begin
      p    = {32'b0, a} * {32'b0, b};
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 0) begin
      r.hi = a;
      r.lo = 32'hFFFF_FFFF;
    end else begin
      r.hi = a % b;
      r.lo = a / b;
    end
    return r;
  endfunction

  // Called just after a negedge. Issues a request, follows it to Done and
  // checks latency, ALU opcode sequence and result. Returns at the DONE
  // negedge. ign_at: cycle at which a DIVU Start is pulsed (must be ignored).
  // rst_at: cycle at which rst_n is pulled low, abandoning the operation.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name, input int ign_at, input int rst_at);
    int         edges;
    bit         pat_ok;
    logic [3:0] exp_ctrl;
    res_t       e;
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.OpA   = a;
    bus.OpB   = b;
    sb.push_back('{hi: exp_hi, lo: exp_lo});
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    edges     = 1;
    pat_ok    = 1'b1;
    while (!bus.Done && edges < 200) begin
      if (edges == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({name, "_reset_state"},
              {bus.Busy, bus.Done, bus.Hi, bus.Lo, bus.ALUControl, bus.SrcA, bus.SrcB}, '0);
        void'(sb.pop_front());
        return;
      end
      exp_ctrl = !op ? ADD : ((edges % 2 == 1) ? SLTU : SUB);
      if (bus.ALUControl !== exp_ctrl || bus.Busy !== 1'b1) pat_ok = 1'b0;
      bus.Start = (edges == ign_at);
      if (edges == ign_at) begin
        bus.Op  = 1'b1;
        bus.OpA = 32'd1000;
        bus.OpB = 32'd3;
      end
      @(negedge clk);
      edges++;
    end
    bus.Start = 1'b0;
    check({name, "_done_seen"}, bus.Done, 1'b1);
    check({name, "_latency"}, edges, op ? 65 : 33);
    check({name, "_alu_ctrl_seq"}, pat_ok, 1'b1);
    check({name, "_done_bus"}, {bus.Busy, bus.ALUControl, bus.SrcA, bus.SrcB}, {1'b1, 68'b0});
    e = sb.pop_front();
    check({name, "_hilo"}, {bus.Hi, bus.Lo}, {e.hi, e.lo});
    last_res = e;
  endtask

  // Cycle after DONE: Done must have dropped, Busy low, Hi/Lo held.
  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_after_done"}, {bus.Done, bus.Busy}, 2'b00);
    check({name, "_hold"}, {bus.Hi, bus.Lo}, {last_res.hi, last_res.lo});
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'h0,         32'h0001_2345, 32'h0,         32'h0};
    vecs[5] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0};
    vecs[6] = '{1'b1, 32'd5,         32'd9,         32'd5,         32'd0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};

    rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 1'b0;
    bus.OpA   = '0;
    bus.OpB   = '0;
    repeat (2) @(negedge clk);
    check("reset_state",
          {bus.Busy, bus.Done, bus.Hi, bus.Lo, bus.ALUControl, bus.SrcA, bus.SrcB}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {bus.Busy, bus.Done, bus.ALUControl}, '0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i), 0, 0);
      check_idle($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      res_t        r;
      op = 1'(i % 2);
      a  = $urandom;
      b  = (i == 5) ? 32'($urandom_range(1, 255)) : $urandom;
      r  = model(op, a, b);
      run_op(op, a, b, r.hi, r.lo, $sformatf("rnd%0d", i), 0, 0);
      check_idle($sformatf("rnd%0d", i));
    end

    // MULTU 3*5 with DIVU Start pulses at cycle 10 and during DONE, both ignored.
    run_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, "ign", 10, 0);
    bus.Start = 1'b1;
    bus.Op    = 1'b1;
    bus.OpA   = 32'd1000;
    bus.OpB   = 32'd3;
    check_idle("ign");
    // Start held into the cycle after Done, now with a new request: accepted.
    run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, "b2b", 0, 0);
    check_idle("b2b");

    // Reset during a MULTU, then a clean MULTU.
    run_op(1'b0, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0626_0060, "rst", 0, 20);
    @(negedge clk);
    check("rst_held", {bus.Busy, bus.Done, bus.Hi, bus.Lo}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, "post_rst", 0, 0);
    check_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
